// File: rtl/event_generator.sv
// Event generator: bursts of rectangular pulses between two signed levels.
// A trigger rising edge starts a burst of `count` pulses (0 = continuous);
// each pulse is w cycles at high_level followed by p-w cycles at low_level.
module event_generator #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trig,
  input  logic                 stop,
  input  logic [CW-1:0]        period,
  input  logic [CW-1:0]        width,
  input  logic [CW-1:0]        count,
  input  logic signed [DW-1:0] high_level,
  input  logic signed [DW-1:0] low_level,
  output logic signed [DW-1:0] dout,
  output logic                 marker,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        emitted
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t               r_state;
  logic                 r_trig_q;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_w_m1;
  logic [CW-1:0]        r_l_m1;
  logic [CW-1:0]        r_count;
  logic signed [DW-1:0] r_high;
  logic signed [DW-1:0] r_low;
  logic signed [DW-1:0] r_dout;
  logic                 r_marker;
  logic                 r_busy;
  logic                 r_done;
  logic [CW-1:0]        r_emitted;

  logic                 w_trig_edge;
  logic [CW-1:0]        w_w_eff;
  logic [CW-1:0]        w_w_m1;
  logic [CW-1:0]        w_l_m1;
  logic                 w_more;

  assign w_trig_edge = trig & ~r_trig_q;

  // Phase reload values are stored minus one so the down-counter ends at 0.
  // p = max(period, w+1) means the low phase is period-w when period > w,
  // else exactly 1 cycle; computing it this way never needs a CW+1 bit sum.
  assign w_w_eff = (width == '0) ? CW'(1) : width;
  assign w_w_m1  = w_w_eff - CW'(1);
  assign w_l_m1  = (period > w_w_eff) ? (period - w_w_eff - CW'(1)) : '0;

  // Another pulse is due at the end of LOW in continuous mode or while short of count
  assign w_more = (r_count == '0) || (r_emitted < r_count);

  // Main FSM; every output is a register updated here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_trig_q  <= 1'b1;  // a trig held high through reset must not look like an edge
      r_cnt     <= '0;
      r_w_m1    <= '0;
      r_l_m1    <= '0;
      r_count   <= '0;
      r_high    <= '0;
      r_low     <= '0;
      r_dout    <= '0;
      r_marker  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_emitted <= '0;
    end else begin
      r_trig_q <= trig;
      r_done   <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a same-cycle trigger; emitted is kept
        r_state  <= S_IDLE;
        r_dout   <= low_level;
        r_marker <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_dout   <= low_level;
            r_marker <= 1'b0;
            r_busy   <= 1'b0;
            if (w_trig_edge) begin
              r_w_m1    <= w_w_m1;
              r_l_m1    <= w_l_m1;
              r_count   <= count;
              r_high    <= high_level;
              r_low     <= low_level;
              r_cnt     <= w_w_m1;
              r_state   <= S_HIGH;
              r_dout    <= high_level;
              r_marker  <= 1'b1;
              r_busy    <= 1'b1;
              r_emitted <= CW'(1);
            end
          end
          S_HIGH: begin
            if (r_cnt == '0) begin
              r_state  <= S_LOW;
              r_cnt    <= r_l_m1;
              r_dout   <= r_low;
              r_marker <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          S_LOW: begin
            if (r_cnt == '0) begin
              if (w_more) begin
                r_state   <= S_HIGH;
                r_cnt     <= r_w_m1;
                r_dout    <= r_high;
                r_marker  <= 1'b1;
                // saturate in continuous mode; finite bursts never reach all-ones here
                if (r_emitted != '1) r_emitted <= r_emitted + CW'(1);
              end else begin
                r_state  <= S_IDLE;
                r_dout   <= low_level;
                r_marker <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_dout   <= low_level;
            r_marker <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout    = r_dout;
  assign marker  = r_marker;
  assign busy    = r_busy;
  assign done    = r_done;
  assign emitted = r_emitted;

endmodule

// File: doc/event_generator.md
EVENT_GENERATOR -- requirements
Module: event_generator

Interface
REQ-001 SHALL have parameter DW, default 16: data width of the output sample and level inputs (signed).
REQ-002 SHALL have parameter CW, default 16: width of the period, width, count and emitted-count fields.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port trig, input, 1: start request, acted on at its rising edge.
REQ-006 SHALL have port stop, input, 1: level-sensitive abort.
REQ-007 SHALL have port period, input, CW: pulse repetition period in clk cycles.
REQ-008 SHALL have port width, input, CW: pulse high time in clk cycles.
REQ-009 SHALL have port count, input, CW: number of pulses per burst; 0 = continuous.
REQ-010 SHALL have port high_level, input, DW signed: output value during the high phase.
REQ-011 SHALL have port low_level, input, DW signed: output value when idle or in the low phase.
REQ-012 SHALL have port dout, output, DW signed: registered event waveform, fed to outputa.
REQ-013 SHALL have port marker, output, 1: high exactly while dout = high_level, fed to an outputinterp or trigger line.
REQ-014 SHALL have port busy, output, 1: high in the HIGH and LOW states.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when a finite burst completes.
REQ-016 SHALL have port emitted, output, CW: number of pulses started in the current or most recent burst, reported on a status word.

Function
REQ-017 SHALL implement states IDLE, HIGH and LOW; all outputs SHALL be registered.
REQ-018 SHALL detect a trigger edge as trig=1 in cycle n with trig=0 sampled in cycle n-1, using a registered previous value.
REQ-019 SHALL, on a trigger edge in IDLE with stop=0, do all of the following:
- latch period, width, count, high_level and low_level;
- clear emitted, then set it to 1;
- enter HIGH so that dout=high_level and marker=1 from cycle n+1.
REQ-020 SHALL hold the latched parameters for the whole burst; input changes while busy SHALL take effect only at the next start.
REQ-021 SHALL use an effective width w = max(width,1) and an effective period p = max(period, w+1).
REQ-022 SHALL hold HIGH for exactly w cycles, then LOW for exactly p-w cycles.
REQ-023 At the end of LOW, with more pulses due (count=0, or emitted<count), SHALL enter HIGH on the next cycle with no gap and increment emitted.
REQ-024 At the end of LOW, with emitted=count (count>0), SHALL go to IDLE and assert done for that one cycle.
REQ-025 SHALL count the phase with a single CW-bit down-counter reloaded on each phase entry; no arithmetic SHALL overflow for any input value.
REQ-026 SHALL, in continuous mode, saturate emitted at 2^CW-1 rather than wrap, while pulses continue.
REQ-027 SHALL ignore trigger edges while busy; no retrigger and no restart.
REQ-028 SHALL, when stop=1 in any cycle, go to IDLE on the next edge with dout=low_level, marker=0, busy=0 and done=0, and SHALL retain emitted.
REQ-029 SHALL give stop priority over a simultaneous trigger edge; no start occurs.
REQ-030 SHALL make dout=low_level in IDLE, tracking the live low_level input.
REQ-031 SHALL make dout in LOW equal the latched low_level.

Reset
REQ-032 SHALL, while reset=0, immediately force: state IDLE, dout=0, marker=0, busy=0, done=0, emitted=0, and trig history=1 so that a trig held high through reset does not start a burst.
REQ-033 SHALL let a reset assertion mid-burst abort the burst immediately, with no done pulse.
REQ-034 SHALL release from reset synchronously to clk, with the first possible start on the second edge after release.

Verification
REQ-035 Bench SHALL cover:
- Single burst: period=10, width=3, count=4, high=1000, low=-1000, trig edge → four pulses, each 3 cycles at 1000 then 7 cycles at -1000, 40 busy cycles, emitted=4, done one cycle.
- Degenerate timing: width=0, period=0, count=2 → pulses 1 cycle high, 1 cycle low, done after 4 cycles.
- Continuous: count=0, period=5, width=2, run 100 cycles, then stop=1 → 20 pulses, emitted=20, idle one cycle after stop, done never asserted.
- Retrigger and priority:
  - trig edge during a burst → waveform unchanged;
  - trig edge and stop=1 in the same IDLE cycle → no start.
- Parameter latch: change width from 3 to 8 mid-burst → current burst keeps w=3; next burst uses w=8.
- Reset: reset=0 in the middle of HIGH → dout=0, busy=0, emitted=0 asynchronously; trig held high across release → no burst until a fresh rising edge.
